// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, sequencer state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

  // 4-bit opcodes carried in the top nibble of every instruction
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LDI  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b0111;
  localparam logic [3:0] OP_BEQZ = 4'b1000;
  localparam logic [3:0] OP_STR  = 4'b1001;

  // Sequencer state encoding, shared with the decoder and benches
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FETCH  = ST_FETCH,
    LOAD   = ST_LOAD,
    EXEC   = ST_EXEC,
    HALTED = ST_HALTED
  } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between fetch_sequencer, instruction memory, decoder and datapath.
// Latency: n/a (wires only). Backpressure: stall from the datapath holds EXEC.
// Ports: master = sequencer side (drives imem_addr/instr/opcode/ir_valid/pc/halted/retired),
//        slave = environment side (drives run/imem_rdata/stall/ldpc/target/halt).
interface fetch_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) ();
  logic               run;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         opcode;
  logic               ir_valid;
  logic               stall;
  logic               ldpc;
  logic [PC_W-1:0]    target;
  logic               halt;
  logic [PC_W-1:0]    pc;
  logic               halted;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  run, imem_rdata, stall, ldpc, target, halt,
    output imem_addr, instr, opcode, ir_valid, pc, halted, retired
  );

  modport slave (
    output run, imem_rdata, stall, ldpc, target, halt,
    input  imem_addr, instr, opcode, ir_valid, pc, halted, retired
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter register with load/increment mux; increment wraps at 2^PC_W.
// Latency: new PC visible the cycle after inc/load. Backpressure: none (caller gates inc/load).
// Ports: clk, rst (async active-high), inc, load, target -> pc.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  // load wins over inc; the FSM never asserts both, but the order is explicit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: owns PC, latches IR, strobes ir_valid for execute.
// Latency: 3 cycles per instruction (FETCH, LOAD, EXEC) plus one per stall cycle.
// Backpressure: stall holds EXEC with ir_valid high and no PC/counter change.
// Ports: clk, rst (async active-high), bus (fetch_sequencer_if.master).
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  state_e             state;
  state_e             state_nxt;
  logic               pc_inc;
  logic               pc_load;
  logic               ir_load;
  logic               ret_inc;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   ret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // halt > ldpc > increment; ldpc/halt only matter on an unstalled EXEC exit
  always_comb begin
    state_nxt = state;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    ir_load   = 1'b0;
    ret_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.run) state_nxt = FETCH;
      end
      FETCH: begin
        state_nxt = LOAD;
      end
      LOAD: begin
        ir_load   = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        if (!bus.stall) begin
          if (bus.halt) begin
            // pc keeps addressing the HALT instruction
            state_nxt = HALTED;
          end else begin
            ret_inc   = 1'b1;
            pc_load   = bus.ldpc;
            pc_inc    = !bus.ldpc;
            state_nxt = FETCH;
          end
        end
      end
      HALTED: begin
        // resume skips past the HALT instruction
        if (bus.run) begin
          pc_inc    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  pc_unit #(.PC_W(PC_W)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (bus.target),
    .pc     (pc)
  );

  // memory data is valid in LOAD, one cycle after FETCH presented the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
    end else if (ir_load) begin
      ir <= bus.imem_rdata;
    end
  end

  // retired counter saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret <= '0;
    end else if (ret_inc && (ret != '1)) begin
      ret <= ret + 1'b1;
    end
  end

  // ir_valid/halted decode straight from state so an async reset drops them at once
  assign bus.imem_addr = pc;
  assign bus.pc        = pc;
  assign bus.instr     = ir;
  assign bus.opcode    = ir[INSTR_W-1 -: 4];
  assign bus.ir_valid  = (state == EXEC);
  assign bus.halted    = (state == HALTED);
  assign bus.retired   = ret;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table, corner sequences, random vs model.
// Latency: n/a. Backpressure: stall driven by the bench.
// Ports: none (top-level bench).
module tb_fetch_sequencer;
  import cpu_pkg::*;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 6;   // small counter so saturation is reachable quickly
  localparam int RET_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [INSTR_W-1:0] imem [256];
  always @(posedge clk) bus.imem_rdata <= imem[bus.imem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic run, input logic stall, input logic ldpc,
                       input logic halt, input logic [7:0] tgt);
    bus.run    = run;
    bus.stall  = stall;
    bus.ldpc   = ldpc;
    bus.halt   = halt;
    bus.target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        run, stall, ldpc, halt;
    logic [7:0]  tgt;
    logic [7:0]  e_pc;
    logic        e_iv, e_halted;
    logic [15:0] e_instr;
    int          e_ret;
  } vec_t;

  function automatic vec_t mk(logic run, logic stall, logic ldpc, logic halt, logic [7:0] tgt,
                              logic [7:0] e_pc, logic e_iv, logic e_halted,
                              logic [15:0] e_instr, int e_ret);
    vec_t v;
    v.run = run; v.stall = stall; v.ldpc = ldpc; v.halt = halt; v.tgt = tgt;
    v.e_pc = e_pc; v.e_iv = e_iv; v.e_halted = e_halted; v.e_instr = e_instr; v.e_ret = e_ret;
    return v;
  endfunction

  localparam logic [15:0] I0 = {OP_ADD,  12'hA01};
  localparam logic [15:0] I1 = {OP_SUB,  12'hB02};
  localparam logic [15:0] I2 = {OP_HALT, 12'hC03};

  vec_t vecs[11];
  int   mpc, mret, iv_hi, ns, k;
  logic h, l;
  logic [7:0] t;
  logic [15:0] e_in;

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = '0;
    imem[0]    = I0;
    imem[1]    = I1;
    imem[2]    = I2;
    imem[3]    = {OP_JMP,  12'hD04};
    imem[8'h40] = {OP_LDI, 12'hE05};
    imem[8'h41] = {OP_ADD, 12'hF06};
    imem[8'h42] = {OP_XOR, 12'h107};
    imem[8'hFF] = {OP_AND, 12'h208};

    // inputs applied, then expected state after the next edge
    vecs[0]  = mk(1,0,0,0,8'h00, 8'd0,0,0,16'h0,0);   // IDLE -> FETCH
    vecs[1]  = mk(0,0,0,0,8'h00, 8'd0,0,0,16'h0,0);   // LOAD
    vecs[2]  = mk(1,0,0,0,8'h00, 8'd0,1,0,I0,0);      // EXEC ADD, run ignored in LOAD
    vecs[3]  = mk(0,0,0,0,8'h00, 8'd1,0,0,I0,1);      // FETCH pc=1
    vecs[4]  = mk(0,0,1,1,8'h33, 8'd1,0,0,I0,1);      // ldpc/halt ignored in FETCH
    vecs[5]  = mk(0,0,0,0,8'h00, 8'd1,1,0,I1,1);      // EXEC SUB
    vecs[6]  = mk(0,0,0,0,8'h00, 8'd2,0,0,I1,2);
    vecs[7]  = mk(0,0,0,0,8'h00, 8'd2,0,0,I1,2);
    vecs[8]  = mk(0,0,0,0,8'h00, 8'd2,1,0,I2,2);      // EXEC HALT
    vecs[9]  = mk(0,0,0,1,8'h00, 8'd2,0,1,I2,2);      // HALTED, pc stays on HALT
    vecs[10] = mk(0,0,0,0,8'h00, 8'd2,0,1,I2,2);

    drive(0,0,0,0,8'h00);
    #12;
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_ir_valid", 32'(bus.ir_valid), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_retired", 32'(bus.retired), 0);
    chk("rst_instr", 32'(bus.instr), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].run, vecs[i].stall, vecs[i].ldpc, vecs[i].halt, vecs[i].tgt);
      step();
      e_in = vecs[i].e_instr;
      chk($sformatf("tbl%0d_pc", i),        32'(bus.pc),        32'(vecs[i].e_pc));
      chk($sformatf("tbl%0d_addr", i),      32'(bus.imem_addr), 32'(vecs[i].e_pc));
      chk($sformatf("tbl%0d_ir_valid", i),  32'(bus.ir_valid),  32'(vecs[i].e_iv));
      chk($sformatf("tbl%0d_halted", i),    32'(bus.halted),    32'(vecs[i].e_halted));
      chk($sformatf("tbl%0d_instr", i),     32'(bus.instr),     32'(e_in));
      chk($sformatf("tbl%0d_opcode", i),    32'(bus.opcode),    32'(e_in[15:12]));
      chk($sformatf("tbl%0d_retired", i),   32'(bus.retired),   32'(vecs[i].e_ret));
    end

    // resume from HALTED then jump
    drive(1,0,0,0,8'h00); step();
    chk("resume_pc", 32'(bus.pc), 3);
    chk("resume_halted", 32'(bus.halted), 0);
    drive(0,0,0,0,8'h00); step(); step();
    chk("jmp_opcode", 32'(bus.opcode), 32'(OP_JMP));
    chk("jmp_ir_valid", 32'(bus.ir_valid), 1);
    drive(0,0,1,0,8'h40); step();
    chk("jmp_addr", 32'(bus.imem_addr), 32'h40);
    chk("jmp_retired", 32'(bus.retired), 3);

    // halt and ldpc together: halt wins
    drive(0,0,0,0,8'h00); step(); step();
    chk("coll_instr", 32'(bus.instr), 32'(imem[8'h40]));
    drive(0,0,1,1,8'h10); step();
    chk("coll_halted", 32'(bus.halted), 1);
    chk("coll_pc", 32'(bus.pc), 32'h40);
    chk("coll_retired", 32'(bus.retired), 3);
    drive(1,0,0,0,8'h00); step();
    chk("coll_resume_pc", 32'(bus.pc), 32'h41);
    chk("coll_resume_iv", 32'(bus.ir_valid), 0);

    // four stall cycles stretch EXEC to five
    drive(0,0,0,0,8'h00); step(); step();
    iv_hi = 0;
    if (bus.ir_valid) iv_hi++;
    for (int i = 0; i < 4; i++) begin
      drive(0,1,1,0,8'h99); step();
      if (bus.ir_valid) iv_hi++;
      chk("stall_pc_hold", 32'(bus.pc), 32'h41);
    end
    drive(0,0,0,0,8'h00); step();
    chk("stall_iv_cycles", 32'(iv_hi), 5);
    chk("stall_pc", 32'(bus.pc), 32'h42);
    chk("stall_retired", 32'(bus.retired), 4);
    chk("stall_exit_iv", 32'(bus.ir_valid), 0);

    // pc wrap from 0xFF
    step(); step();
    drive(0,0,1,0,8'hFF); step();
    chk("wrap_pre_pc", 32'(bus.pc), 32'hFF);
    drive(0,0,0,0,8'h00); step(); step();
    chk("wrap_instr", 32'(bus.instr), 32'(imem[8'hFF]));
    step();
    chk("wrap_pc", 32'(bus.pc), 0);
    chk("wrap_retired", 32'(bus.retired), 6);

    // async reset in EXEC with ldpc pending
    step(); step();
    chk("rstx_iv_before", 32'(bus.ir_valid), 1);
    drive(0,0,1,0,8'h77);
    #2 rst = 1'b1;
    #1;
    chk("rstx_pc", 32'(bus.pc), 0);
    chk("rstx_addr", 32'(bus.imem_addr), 0);
    chk("rstx_iv", 32'(bus.ir_valid), 0);
    chk("rstx_halted", 32'(bus.halted), 0);
    chk("rstx_instr", 32'(bus.instr), 0);
    chk("rstx_opcode", 32'(bus.opcode), 0);
    chk("rstx_retired", 32'(bus.retired), 0);
    @(posedge clk); #3;
    rst = 1'b0;
    drive(0,0,0,0,8'h00); step(); step();
    chk("rstx_idle_pc", 32'(bus.pc), 0);
    chk("rstx_idle_iv", 32'(bus.ir_valid), 0);
    drive(1,0,0,0,8'h00); step();
    drive(0,0,0,0,8'h00); step(); step();
    chk("rstx_first_exec", 32'(bus.ir_valid), 1);
    chk("rstx_first_pc", 32'(bus.pc), 0);
    step();
    mpc  = 1;
    mret = 1;
    chk("rnd_start_pc", 32'(bus.pc), 32'(mpc));

    // random program vs transaction-level model
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    for (int n = 0; n < 200; n++) begin
      chk("rnd_fetch_iv", 32'(bus.ir_valid), 0);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom)); step();
      chk("rnd_load_iv", 32'(bus.ir_valid), 0);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom)); step();
      chk("rnd_exec_iv", 32'(bus.ir_valid), 1);
      chk("rnd_exec_pc", 32'(bus.pc), 32'(mpc));
      chk("rnd_exec_instr", 32'(bus.instr), 32'(imem[mpc]));
      ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int s = 0; s < ns; s++) begin
        drive(1'($urandom), 1'b1, 1'($urandom), 1'($urandom), 8'($urandom)); step();
        chk("rnd_stall_iv", 32'(bus.ir_valid), 1);
        chk("rnd_stall_pc", 32'(bus.pc), 32'(mpc));
      end
      h = ($urandom_range(0, 7) == 0);
      l = 1'($urandom);
      t = 8'($urandom);
      drive(1'($urandom), 1'b0, l, h, t); step();
      if (h) begin
        chk("rnd_halt_halted", 32'(bus.halted), 1);
        chk("rnd_halt_pc", 32'(bus.pc), 32'(mpc));
        chk("rnd_halt_retired", 32'(bus.retired), 32'(mret));
        k = int'($urandom_range(0, 2));
        for (int w = 0; w < k; w++) begin
          drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom)); step();
          chk("rnd_halt_hold", 32'(bus.halted), 1);
        end
        drive(1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom)); step();
        mpc = (mpc + 1) % 256;
        chk("rnd_resume_halted", 32'(bus.halted), 0);
        chk("rnd_resume_pc", 32'(bus.pc), 32'(mpc));
      end else begin
        mpc  = l ? int'(t) : (mpc + 1) % 256;
        mret = (mret < RET_MAX) ? mret + 1 : RET_MAX;
        chk("rnd_next_pc", 32'(bus.pc), 32'(mpc));
        chk("rnd_retired", 32'(bus.retired), 32'(mret));
      end
    end
    chk("ret_saturated", 32'(bus.retired), 32'(RET_MAX));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and issue sequencer for the 4-bit-opcode CPU: owns the PC, reads instruction memory, latches the instruction register and presents `opcode` to the control decoder. It consumes the decoder's `ldpc` and `halt` outputs plus the ALU result as jump target, making it the driving end of the control decoder's opcode-in / control-out interface. It sits between instruction memory, the control decoder and the datapath.

## Interface
- `PC_W`, default 8: PC and instruction-memory address width.
- `INSTR_W`, default 16: instruction width; opcode is `instr[INSTR_W-1 -: 4]`.
- `CNT_W`, default 16: retired-instruction counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: start from IDLE, or resume from HALTED; level-sampled.
- `imem_addr` out PC_W: instruction-memory address; always equals `pc`.
- `imem_rdata` in INSTR_W: synchronous-read memory data, valid one cycle after `imem_addr`.
- `instr` out INSTR_W: latched instruction register (IR).
- `opcode` out 4: `instr[INSTR_W-1 -: 4]`, drives the control decoder.
- `ir_valid` out 1: execute strobe; the datapath ANDs `reg_write`/`mem_write` with it.
- `stall` in 1: datapath not ready; holds EXEC.
- `ldpc` in 1: load PC from `target` (decoder output).
- `target` in PC_W: jump/branch target (ALU result).
- `halt` in 1: halt request (decoder output).
- `pc` out PC_W: current PC.
- `halted` out 1: high in HALTED.
- `retired` out CNT_W: count of completed non-halt instructions, saturating.

## Operation
- States: IDLE, FETCH, LOAD, EXEC, HALTED.
- IDLE: `run`=1 -> FETCH, else stay.
- FETCH: address `pc` presented -> LOAD.
- LOAD: IR <= `imem_rdata` -> EXEC.
- EXEC: `ir_valid`=1. If `stall`=1, stay in EXEC with `ir_valid` held high and no PC change. Otherwise, on exit:
  - `halt`=1: pc unchanged (still addresses the HALT), -> HALTED; `retired` not incremented.
  - else `ldpc`=1: pc <= `target`, `retired`+1, -> FETCH.
  - else: pc <= pc+1 modulo 2^PC_W, `retired`+1, -> FETCH.
- Priority: `halt` > `ldpc` > increment. `ldpc` and `halt` are ignored outside EXEC.
- HALTED: `halted`=1. `run`=1 -> pc <= pc+1 (wraps), -> FETCH. `run` is ignored in FETCH, LOAD and EXEC.
- Arithmetic: PC increment wraps 2^PC_W-1 -> 0. `retired` saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Reset (async, immediate in any state): state IDLE, `pc`=0, `imem_addr`=0, `instr`=0, `opcode`=0, `ir_valid`=0, `halted`=0, `retired`=0.
- Reset mid-EXEC drops `ir_valid` in the same cycle and suppresses any PC update.
- Three cycles per unstalled instruction (FETCH, LOAD, EXEC). The first EXEC comes 3 cycles after the `run` sample in IDLE.
- `ir_valid` is high exactly one cycle per instruction plus one cycle per stall cycle. Datapath writes commit on the edge that leaves EXEC, i.e. when `stall`=0.
- `opcode` and `instr` are stable from LOAD exit until the next LOAD exit.
- `halted` rises the cycle after the halting EXEC and falls the cycle after `run` is sampled.
- `imem_addr` changes only on the edge leaving EXEC or HALTED.

## Structure
- Shared package `cpu_pkg`: opcode constants (ADD 0000, SUB 0001, LDI 0010, XOR 0011, AND 0100, JMP 0110, HALT 0111, BEQZ 1000, STR 1001) and the state encoding (3-bit, one localparam per state), shared with the decoder and benches.
- One natural sub-module: `pc_unit` (PC register, increment/load mux, wrap). The FSM and counter live in the top.
- Top-level integration instantiates `fetch_sequencer` alongside the control decoder; `zero`-qualified `ldpc` arrives already resolved.

## Test plan
- Straight line: imem[0..2]=ADD,SUB,HALT; `run` pulse -> `ir_valid` at cycles 3, 6, 9; `pc` 0 -> 1 -> 2; `halted`=1, `pc`=2, `retired`=2.
- Jump: imem[3]=JMP with `target`=0x40, `ldpc`=1 in EXEC -> next `imem_addr`=0x40, `retired`+1.
- Halt/ldpc collision: `halt`=1 and `ldpc`=1 in the same EXEC -> HALTED, `pc` unchanged, `retired` unchanged. Then `run` -> `pc`=old+1 and FETCH.
- Stall: `stall`=1 for 4 cycles in EXEC -> `ir_valid` high for 5 cycles, single PC increment, `retired`+1.
- Wrap/saturate: `pc`=0xFF executing ADD -> `pc`=0x00. `retired` preset to 0xFFFF by run-length -> stays 0xFFFF.
- Async reset asserted mid-EXEC with `ldpc`=1 -> all outputs at reset values immediately, state IDLE, no PC load.
